bcd_display_counter: RTL and testbench
======================================

Name: bcd_display_counter

Overview:
- Parametrised N-digit decimal counter driving N seven-segment displays.
- Advances once per TICK_DIV clocks. Supports up/down counting, a synchronous clear, and a run/pause toggle from a raw push-button.
- Sits at top level between the board clock, push-buttons and HEXn pins. Used as the board-level status and timer display.

Parameters:
- NUM_DIGITS, 4, number of BCD digits and 7-seg outputs; legal 1..8.
- TICK_DIV, 50_000_000, clocks per count step; legal >=2; divider width is $clog2(TICK_DIV).

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge.
- RESET_N  in  1  reset, synchronous, active-low; sampled on posedge CLOCK_50.
- up  in  1  count direction: 1 = up, 0 = down; sampled at each tick.
- clear  in  1  synchronous clear; active-high, level.
- key_run_n  in  1  raw asynchronous push-button, active-low; each press toggles run/pause.
- running  out  1  current run state.
- tick  out  1  one-cycle pulse on every divider terminal count, while running.
- wrap  out  1  one-cycle pulse when the counter wraps (up 99..9->0, or down 0->99..9).
- bcd  out  4*NUM_DIGITS  digit values; digit 0 (least significant) in bcd[3:0].
- hex  out  7*NUM_DIGITS  segment patterns, active-low, bit order gfedcba; digit k in hex[7k+6:7k].

Behaviour:
- Reset (RESET_N=0 at posedge):
  - divider=0, all digits=0, running=1, tick=0, wrap=0.
  - Synchroniser and edge-detect flops load 1 (button released).
  - hex shows "0" on every digit. With the optional feature enabled, upper digits are blank instead (see Optional Feature).
- Button input:
  - key_run_n passes through a 2-flop synchroniser, then a registered copy for edge detection.
  - A falling edge (prev=1, cur=0) toggles running, 3 cycles after the input edge.
  - No debounce in this block; bench stimulus is clean.
- Divider:
  - Counts only while running=1: 0..TICK_DIV-1, then back to 0.
  - tick=1 in the cycle after the divider register equals TICK_DIV-1; tick is registered.
  - Exactly one tick per TICK_DIV clocks; no off-by-one.
  - Pausing freezes the divider value. Resuming continues from the frozen value.
- Count step: on the same edge that asserts tick, the digits update.
  - up=1: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit.
  - up=0: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - A carry or borrow out of the top digit wraps the whole counter and asserts wrap, registered, on the same edge that updates the digits.
  - Digits never hold values 10..15.
- Clear:
  - clear=1 sets divider=0 and digits=0. tick=0 and wrap=0 that cycle.
  - clear overrides a coincident tick.
  - running is unaffected.
- Priority: RESET_N > clear > count step.
  - A button edge coincident with clear still toggles running.
- Direction:
  - up is sampled only at the step edge.
  - Changing up mid-period takes effect at the next step; no glitch, no extra step.
- Outputs:
  - hex is combinational from the registered bcd. hex changes in the same cycle as bcd.
  - Encoding, hex values (gfedcba): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; blank=7F.
- Reset mid-count: takes effect at the next edge regardless of running, clear or divider state.

Optional Feature:
- Macro: BCD_DISPLAY_LZB_EN.
- Defined: leading-zero blanking.
  - Digit k>0 shows 7F when it and all higher digits are 0.
  - Digit 0 is never blanked.
  - bcd output is unchanged.
- Undefined: all digits are always decoded; the blanking logic is absent.

Test Plan:
- NUM_DIGITS=2, TICK_DIV=4, reset held 2 cycles, up=1, run 400 clocks -> tick every 4th cycle.
  - bcd counts 00..99; wrap pulses once at 99->00 (100th tick).
  - hex[6:0]=40 after the wrap.
- up=0 from reset -> first tick gives bcd=99 with wrap=1, then 98, 97. Switch up=1 mid-period -> next tick gives 98.
- Assert clear on the cycle the divider equals 3 with bcd=42 -> bcd=00, tick=0, divider=0.
  - The next tick arrives exactly 4 cycles after clear deasserts.
- Press key_run_n at divider=1 -> running=0 three cycles later; bcd is frozen for 50 clocks.
  - Second press -> running=1; the first tick comes TICK_DIV minus the frozen divider value cycles after resume.
- Assert RESET_N=0 for one cycle with bcd=57 and running=0 -> next cycle: bcd=00, running=1, divider=0, tick=0.
- With BCD_DISPLAY_LZB_EN defined, NUM_DIGITS=4, bcd=0007 -> hex digits 3..1 = 7F, digit 0 = 78.
  - At bcd=0000: only digit 0 shows 40.

Source files
------------

// File: rtl/bcd_display_counter.sv
// N-digit BCD up/down counter stepping once per TICK_DIV clocks, with run/pause push-button and 7-seg decode.
// Optional leading-zero blanking on the segment outputs when BCD_DISPLAY_LZB_EN is defined.
module bcd_display_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50_000_000
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic                    up,
  input  logic                    clear,
  input  logic                    key_run_n,
  output logic                    running,
  output logic                    tick,
  output logic                    wrap,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [7*NUM_DIGITS-1:0] hex
);

  localparam int              DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic                    sync1_q, sync2_q, prev_q;
  logic                    run_q, run_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    tick_q, tick_d;
  logic                    wrap_q, wrap_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic                    key_fall;
  logic                    carry;
  logic [3:0]              dig;
  logic [3:0]              dig_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    key_fall = prev_q & ~sync2_q;
    run_d    = run_q ^ key_fall;
    div_d    = div_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    bcd_d    = bcd_q;
    carry    = 1'b0;
    dig      = 4'd0;
    dig_nxt  = 4'd0;
    if (clear) begin
      div_d = '0;
      bcd_d = '0;
    end else if (run_q) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        tick_d = 1'b1;
        // Ripple carry/borrow from digit 0; whatever survives the top digit is the wrap.
        carry  = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
          dig     = bcd_q[4*k +: 4];
          dig_nxt = dig;
          if (carry) begin
            if (up) begin
              if (dig == 4'd9) dig_nxt = 4'd0;
              else begin
                dig_nxt = dig + 4'd1;
                carry   = 1'b0;
              end
            end else begin
              if (dig == 4'd0) dig_nxt = 4'd9;
              else begin
                dig_nxt = dig - 4'd1;
                carry   = 1'b0;
              end
            end
          end
          bcd_d[4*k +: 4] = dig_nxt;
        end
        wrap_d = carry;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      run_q   <= 1'b1;
      div_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      sync1_q <= key_run_n;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      run_q   <= run_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      bcd_q   <= bcd_d;
    end
  end

  assign running = run_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign bcd     = bcd_q;

`ifdef BCD_DISPLAY_LZB_EN
  logic [NUM_DIGITS-1:0] blank;
  logic                  lead_zero;

  // Blank digit k>0 while it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    blank     = '0;
    lead_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lead_zero = lead_zero & (bcd_q[4*k +: 4] == 4'd0);
      blank[k]  = lead_zero;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_hex
    assign hex[7*k +: 7] = blank[k] ? 7'h7F : seg7(bcd_q[4*k +: 4]);
  end
`else
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_hex
    assign hex[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
  end
`endif

endmodule

// File: tb/tb_bcd_display_counter.sv
// Directed bench for bcd_display_counter: 2 digits, TICK_DIV=4; checks count, wrap, direction, clear, pause and reset.
module tb_bcd_display_counter;
  localparam int ND = 2;
  localparam int TD = 4;

  logic          CLOCK_50 = 1'b0;
  logic          RESET_N;
  logic          up;
  logic          clear;
  logic          key_run_n;
  logic          running;
  logic          tick;
  logic          wrap;
  logic [4*ND-1:0] bcd;
  logic [7*ND-1:0] hex;

  int n_run  = 0;
  int n_fail = 0;

  bcd_display_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .up       (up),
    .clear    (clear),
    .key_run_n(key_run_n),
    .running  (running),
    .tick     (tick),
    .wrap     (wrap),
    .bcd      (bcd),
    .hex      (hex)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'h40;
      1: seg = 7'h79;
      2: seg = 7'h24;
      3: seg = 7'h30;
      4: seg = 7'h19;
      5: seg = 7'h12;
      6: seg = 7'h02;
      7: seg = 7'h78;
      8: seg = 7'h00;
      9: seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  function automatic logic [13:0] exp_hex(input int n);
    logic [6:0] hi;
    hi = seg(n / 10);
`ifdef BCD_DISPLAY_LZB_EN
    if (n / 10 == 0) hi = 7'h7F;
`endif
    exp_hex = {hi, seg(n % 10)};
  endfunction

  function automatic logic [7:0] exp_bcd(input int n);
    exp_bcd = {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic chk_all(input string tag, input int n, input bit t, input bit w, input bit r);
    chk({tag, "/bcd"}, 32'(bcd), 32'(exp_bcd(n)));
    chk({tag, "/hex"}, 32'(hex), 32'(exp_hex(n)));
    chk({tag, "/tick"}, 32'(tick), 32'(t));
    chk({tag, "/wrap"}, 32'(wrap), 32'(w));
    chk({tag, "/running"}, 32'(running), 32'(r));
  endtask

  initial begin
    RESET_N   = 1'b0;
    up        = 1'b1;
    clear     = 1'b0;
    key_run_n = 1'b1;

    // Reset state, then 100 up-steps ending in a wrap to 00
    step(2);
    chk_all("reset", 0, 1'b0, 1'b0, 1'b1);
    RESET_N = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      step(1);
      chk_all("up", (i / 4) % 100, (i % 4) == 0, i == 400, 1'b1);
    end
    chk("wrap_hex0", 32'(hex[6:0]), 32'h40);

    // Down count from reset, then direction change mid-period
    up      = 1'b0;
    RESET_N = 1'b0;
    step(1);
    chk_all("rst2", 0, 1'b0, 1'b0, 1'b1);
    RESET_N = 1'b1;
    step(3);
    chk_all("down_pre", 0, 1'b0, 1'b0, 1'b1);
    step(1);
    chk_all("down99", 99, 1'b1, 1'b1, 1'b1);
    step(4);
    chk_all("down98", 98, 1'b1, 1'b0, 1'b1);
    step(4);
    chk_all("down97", 97, 1'b1, 1'b0, 1'b1);
    step(2);
    up = 1'b1;
    step(1);
    chk_all("dir_mid", 97, 1'b0, 1'b0, 1'b1);
    step(1);
    chk_all("dir_up", 98, 1'b1, 1'b0, 1'b1);

    // Clear at divider=3 with bcd=42 overrides the coincident tick
    RESET_N = 1'b0;
    step(1);
    RESET_N = 1'b1;
    step(168);
    chk_all("at42", 42, 1'b1, 1'b0, 1'b1);
    step(3);
    chk_all("pre_clr", 42, 1'b0, 1'b0, 1'b1);
    clear = 1'b1;
    step(1);
    chk_all("clr", 0, 1'b0, 1'b0, 1'b1);
    clear = 1'b0;
    step(3);
    chk_all("post_clr3", 0, 1'b0, 1'b0, 1'b1);
    step(1);
    chk_all("post_clr4", 1, 1'b1, 1'b0, 1'b1);

    // Press at divider=1: divider keeps running until the toggle lands 3 edges later
    step(1);
    chk_all("div1", 1, 1'b0, 1'b0, 1'b1);
    key_run_n = 1'b0;
    step(2);
    chk_all("press_e2", 1, 1'b0, 1'b0, 1'b1);
    step(1);
    chk_all("press_e3", 2, 1'b1, 1'b0, 1'b0);
    key_run_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk_all("frozen", 2, 1'b0, 1'b0, 1'b0);
    end
    key_run_n = 1'b0;
    step(2);
    chk_all("resume_e2", 2, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_all("resume_e3", 2, 1'b0, 1'b0, 1'b1);
    key_run_n = 1'b1;
    step(3);
    chk_all("resume_wait", 2, 1'b0, 1'b0, 1'b1);
    step(1);
    chk_all("resume_tick", 3, 1'b1, 1'b0, 1'b1);

    // Pause with divider frozen at 1; resume ticks TD-1 cycles later
    step(2);
    key_run_n = 1'b0;
    step(2);
    chk_all("p2_tick", 4, 1'b1, 1'b0, 1'b1);
    step(1);
    chk_all("p2_paused", 4, 1'b0, 1'b0, 1'b0);
    key_run_n = 1'b1;
    step(10);
    chk_all("p2_frozen", 4, 1'b0, 1'b0, 1'b0);
    key_run_n = 1'b0;
    step(3);
    chk_all("p2_resume", 4, 1'b0, 1'b0, 1'b1);
    key_run_n = 1'b1;
    step(2);
    chk_all("p2_wait", 4, 1'b0, 1'b0, 1'b1);
    step(1);
    chk_all("p2_tick2", 5, 1'b1, 1'b0, 1'b1);

    // Reset while paused at bcd=57 with divider mid-period
    step(208);
    chk_all("at57", 57, 1'b1, 1'b0, 1'b1);
    key_run_n = 1'b0;
    step(3);
    chk_all("p57", 57, 1'b0, 1'b0, 1'b0);
    key_run_n = 1'b1;
    step(5);
    chk_all("p57_hold", 57, 1'b0, 1'b0, 1'b0);
    RESET_N = 1'b0;
    step(1);
    chk_all("rst_mid", 0, 1'b0, 1'b0, 1'b1);
    RESET_N = 1'b1;
    step(3);
    chk_all("rst_wait", 0, 1'b0, 1'b0, 1'b1);
    step(1);
    chk_all("rst_tick", 1, 1'b1, 1'b0, 1'b1);
    step(24);
    chk_all("at07", 7, 1'b1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
